muldiv_sequencer: RTL and testbench

Iterative multiply/divide unit with its own sequencing controller. It sits beside the ALU in the EX stage of the pipeline. When the decoder flags a mul/div-class instruction, the EX stage pulses `start`. The block then holds the pipeline with `stall_req` until the radix-2 shift-add or shift-subtract iteration completes, and presents a registered result with a one-cycle `done` pulse.

---
 rtl/muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 multiply/divide unit for the EX stage.
// One shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU) step per
// cycle. The unit stalls the pipeline while running and pulses done for one
// cycle with a registered result.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request new operation, sampled only in IDLE
//   op[1:0]           0=MUL 1=MULHU 2=DIVU 3=REMU
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   flush             abort in-flight operation
//   stall_req         hold IF/ID/EX pipeline registers
//   busy              FSM not in IDLE
//   done              one-cycle result-valid pulse
//   result            registered result, held until next completion
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand (MUL*) or divisor (DIV*)
  logic [2*WIDTH-1:0] acc_q, acc_d;        // {hi, lo} product or {rem, quo}
  logic [WIDTH-1:0]   result_q, result_d;

  // Multiply step: conditionally add multiplicand to the high half, then shift
  // the whole {carry, hi, lo} right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // Divide step: shift {rem, quo} left by one and try subtracting the divisor.
  // The shifted remainder needs WIDTH+1 bits; a zero divisor never borrows,
  // which naturally yields quotient all-ones and remainder = dividend.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    borrow   = rem_sh < {1'b0, opnd_q};
    diff     = rem_sh - {1'b0, opnd_q};
    div_next = borrow ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                      : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    step     = op_q[1] ? div_next : mul_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_RUN;
          op_d    = op;
          cnt_d   = CW'(WIDTH);
          opnd_d  = op[1] ? src_b : src_a;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? src_a : src_b)};
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // MULHU and REMU take the high half; MUL and DIVU the low half.
            result_d = op_q[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // stall_req releases in a flush cycle so the pipeline can redirect at once.
  assign stall_req = ((state_q == S_IDLE) && start && !flush) ||
                     ((state_q == S_RUN) && !flush);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         stall_req, busy, done;
  logic [W-1:0] result;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .stall_req(stall_req), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] model_result = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_latency", cyc, e.cyc);
        chk("stall_in_done", stall_req, 0);
        chk("busy_in_done", busy, 1);
        model_result = e.res;
      end
    end
  end

  task automatic accept(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_done);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 chk("stall_on_start", stall_req, 1);
    @(posedge clk);
    #1;
    if (expect_done) begin
      e.res = model(o, a, b);
      e.cyc = cyc + W;
      sb.push_back(e);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int stalls;
    accept(o, a, b, 1'b1);
    start = 1'b0;
    stalls = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      // Inputs change during RUN; the latched operands must be used.
      src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      if (done) break;
      if (stall_req) stalls++;
    end
    chk("stall_cycles", stalls, W);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_flush(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    accept(o, a, b, 1'b0);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("stall_in_flush", stall_req, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("busy_after_flush", busy, 0);
    chk("result_kept_after_flush", result, model_result);
    @(negedge clk);
  endtask

  task automatic run_held(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit seen;
    accept(o, a, b, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < W + 5 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin src_a = $urandom; src_b = $urandom; end
    end
    chk("held_done_seen", seen, 1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("held_start_not_accepted_in_done", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall_req, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_op(2'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'h1234, 32'd0);
    run_op(2'd3, 32'h1234, 32'd0);

    // start with flush in IDLE must not be accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1 chk("stall_start_flush", stall_req, 0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("busy_start_flush", busy, 0);

    run_flush(2'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    @(negedge clk);
    run_op(2'd2, 32'hDEAD_BEEF, 32'd13);

    run_held(2'd3, 32'hCAFE_F00D, 32'd1000);

    // Reset mid-RUN.
    accept(2'd1, 32'h8765_4321, 32'h1234_5678, 1'b0);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_stall", stall_req, 0);
    model_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int sel;
      a = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) b = W'($urandom_range(1, 15));
      else b = $urandom;
      if (($urandom_range(0, 3)) == 0) a = W'($urandom_range(0, 255));
      run_op(2'($urandom), a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
